// File: rtl/multi_button_debounce_pkg.sv
// Shared types and default Go Board timing for the multi-channel button debouncer.
package multi_button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // 25 MHz board clock: 10 ms debounce, 500 ms hold, 100 ms repeat period
  localparam int unsigned CLK_HZ              = 25_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int unsigned DEF_HOLD_CYCLES     = CLK_HZ / 2;
  localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 10;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_button_debounce_channel.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release
// strobes, toggle state and the hold-to-auto-repeat FSM.
module debounce_channel
  import multi_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_HIGH     = 1,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic rpt_o
);

  localparam int CNT_W = cntWidth(int'(DEBOUNCE_CYCLES));
  localparam int TMR_W = cntWidth(int'((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  logic             pin;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;
  logic             rpt_q, rpt_d;
  rpt_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Normalise polarity before the synchroniser so everything downstream means "pressed".
  assign pin = btn_i ^ (ACTIVE_HIGH == 0);

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d   = s2_q;
      cnt_d     = '0;
      press_d   = s2_q;
      release_d = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (press_d) begin
      toggle_d = ~toggle_q;
    end
  end

  // A release always wins over a repeat expiry landing on the same edge.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rpt_d   = 1'b0;
    if (release_d) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d && (REPEAT_EN != 0)) begin
            state_d = HOLD;
            tmr_d   = '0;
          end
        end
        HOLD: begin
          if (tmr_q == HOLD_LAST) begin
            rpt_d   = 1'b1;
            state_d = REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        REPEAT: begin
          if (tmr_q == RPT_LAST) begin
            rpt_d = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      rpt_q     <= 1'b0;
      state_q   <= IDLE;
      tmr_q     <= '0;
    end else begin
      s1_q      <= pin;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
  assign rpt_o     = rpt_q;

endmodule

// File: rtl/multi_button_debounce.sv
// N-channel button front end for the calculator: one independent
// debounce_channel per pin. Outputs use _o because "release" is reserved.
module multi_button_debounce
  import multi_button_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_HIGH     = 1,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_in_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] toggle_o,
  output logic [NUM_CH-1:0] rpt_o
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_HIGH    (ACTIVE_HIGH),
      .REPEAT_EN      (REPEAT_EN),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) uChannel (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_i    (btn_in_i[ch]),
      .level_o  (level_o[ch]),
      .press_o  (press_o[ch]),
      .release_o(release_o[ch]),
      .toggle_o (toggle_o[ch]),
      .rpt_o    (rpt_o[ch])
    );
  end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Scoreboard bench: a history-window reference model predicts every cycle for
// a default build, a REPEAT_EN=0 build and an ACTIVE_HIGH=0 build.
module tb_multi_button_debounce;

  localparam int NUM_CH = 4;
  localparam int DEB    = 8;
  localparam int HOLD   = 20;
  localparam int RPT    = 5;

  typedef struct packed {
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] rel;
    logic [NUM_CH-1:0] toggle;
    logic [NUM_CH-1:0] rpt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH-1:0] btnIn;
  logic [NUM_CH-1:0] btnInv;
  logic [NUM_CH-1:0] level[3], press[3], rel[3], toggle[3], rpt[3];

  obs_t  expQ[$];
  int    testsRun = 0;
  int    failures = 0;
  int    edgeNum  = 0;
  string phase    = "reset";
  bit    countCh3 = 1'b0;
  int    ch3Press = 0;
  int    ch3Rel   = 0;
  int    tglSeq[$];

  bit mLevel[NUM_CH], mPress[NUM_CH], mRel[NUM_CH], mToggle[NUM_CH], mRpt[NUM_CH];
  bit hist[NUM_CH][$];
  int pressEdge[NUM_CH];

  assign btnInv = ~btnIn;

  always #5 clk = ~clk;

  multi_button_debounce #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1), .REPEAT_EN(1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)) dutMain (
    .clk(clk), .rst_n(rst_n), .btn_in_i(btnIn), .level_o(level[0]), .press_o(press[0]),
    .release_o(rel[0]), .toggle_o(toggle[0]), .rpt_o(rpt[0]));

  multi_button_debounce #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1), .REPEAT_EN(0),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)) dutNoRpt (
    .clk(clk), .rst_n(rst_n), .btn_in_i(btnIn), .level_o(level[1]), .press_o(press[1]),
    .release_o(rel[1]), .toggle_o(toggle[1]), .rpt_o(rpt[1]));

  multi_button_debounce #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(0), .REPEAT_EN(1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)) dutInv (
    .clk(clk), .rst_n(rst_n), .btn_in_i(btnInv), .level_o(level[2]), .press_o(press[2]),
    .release_o(rel[2]), .toggle_o(toggle[2]), .rpt_o(rpt[2]));

  task automatic applyStimulus(input logic [NUM_CH-1:0] pins, input logic rstN, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      btnIn = pins;
      rst_n = rstN;
    end
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s/%s edge %0d: got lvl=%b prs=%b rel=%b tgl=%b rpt=%b, want lvl=%b prs=%b rel=%b tgl=%b rpt=%b",
               phase, name, edgeNum, act.level, act.press, act.rel, act.toggle, act.rpt,
               exp.level, exp.press, exp.rel, exp.toggle, exp.rpt);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Level flips once the last DEB synchronised samples (two edges old) all disagree with it;
  // repeats fall at press+HOLD+n*RPT until a release.
  task automatic modelEdge();
    obs_t e;
    bit   stable;
    int   n;
    edgeNum++;
    for (int c = 0; c < NUM_CH; c++) begin
      mPress[c] = 1'b0;
      mRel[c]   = 1'b0;
      mRpt[c]   = 1'b0;
      if (!rst_n) begin
        mLevel[c]    = 1'b0;
        mToggle[c]   = 1'b0;
        pressEdge[c] = -1;
        hist[c].push_back(1'b0);
      end else begin
        hist[c].push_back(btnIn[c]);
        n = hist[c].size();
        if (n >= DEB + 2) begin
          stable = 1'b1;
          for (int j = n - 2 - DEB; j <= n - 3; j++) begin
            if (hist[c][j] == mLevel[c]) stable = 1'b0;
          end
          if (stable) begin
            mLevel[c] = ~mLevel[c];
            if (mLevel[c]) begin
              mPress[c]  = 1'b1;
              mToggle[c] = ~mToggle[c];
            end else begin
              mRel[c] = 1'b1;
            end
          end
        end
        if (mRel[c]) pressEdge[c] = -1;
        if (mPress[c]) pressEdge[c] = edgeNum;
        if (pressEdge[c] >= 0 && (edgeNum - pressEdge[c]) >= HOLD &&
            ((edgeNum - pressEdge[c] - HOLD) % RPT) == 0) mRpt[c] = 1'b1;
      end
      while (hist[c].size() > DEB + 2) void'(hist[c].pop_front());
      e.level[c]  = mLevel[c];
      e.press[c]  = mPress[c];
      e.rel[c]    = mRel[c];
      e.toggle[c] = mToggle[c];
      e.rpt[c]    = mRpt[c];
    end
    expQ.push_back(e);
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) pressEdge[c] = -1;
    forever begin
      @(posedge clk);
      modelEdge();
    end
  end

  // Monitor: DUT outputs are registered, so sample on the falling edge.
  initial begin
    obs_t e;
    obs_t eNoRpt;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        eNoRpt = e;
        eNoRpt.rpt = '0;
        checkOutput("main", {level[0], press[0], rel[0], toggle[0], rpt[0]}, e);
        checkOutput("noRpt", {level[1], press[1], rel[1], toggle[1], rpt[1]}, eNoRpt);
        checkOutput("inv", {level[2], press[2], rel[2], toggle[2], rpt[2]}, e);
        if (countCh3) begin
          if (press[0][3]) begin
            ch3Press++;
            tglSeq.push_back(int'(toggle[0][3]));
          end
          if (rel[0][3]) ch3Rel++;
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] pins;
    int runLeft[NUM_CH];
    rst_n = 1'b0;
    btnIn = '0;
    applyStimulus('0, 1'b0, 3);

    phase = "clean";
    applyStimulus(4'b0001, 1'b1, 30);
    applyStimulus(4'b0000, 1'b1, 20);

    phase = "bounce";
    applyStimulus(4'b0010, 1'b1, 7);
    applyStimulus(4'b0000, 1'b1, 3);
    applyStimulus(4'b0010, 1'b1, 7);
    applyStimulus(4'b0000, 1'b1, 20);

    phase = "repeat";
    applyStimulus(4'b0100, 1'b1, 70);
    applyStimulus(4'b0000, 1'b1, 20);

    phase = "toggle";
    countCh3 = 1'b1;
    repeat (3) begin
      applyStimulus(4'b1000, 1'b1, 15);
      applyStimulus(4'b0000, 1'b1, 15);
    end
    applyStimulus(4'b0000, 1'b1, 10);
    countCh3 = 1'b0;

    phase = "resetHold";
    applyStimulus(4'b0001, 1'b1, 40);
    applyStimulus(4'b0001, 1'b0, 2);
    applyStimulus(4'b0001, 1'b1, 50);
    applyStimulus(4'b0000, 1'b1, 20);

    phase = "random";
    pins = '0;
    for (int c = 0; c < NUM_CH; c++) runLeft[c] = int'($urandom_range(1, 45));
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (runLeft[c] == 0) begin
          pins[c] = ~pins[c];
          runLeft[c] = int'($urandom_range(1, 45));
        end else begin
          runLeft[c]--;
        end
      end
      applyStimulus(pins, ($urandom_range(0, 399) != 0), 1);
    end

    phase = "drain";
    applyStimulus('0, 1'b1, 15);

    checkCount("ch3PressCount", ch3Press, 3);
    checkCount("ch3ReleaseCount", ch3Rel, 3);
    for (int i = 0; i < 3; i++) begin
      checkCount($sformatf("ch3Toggle%0d", i), (i < tglSeq.size()) ? tglSeq[i] : -1, (i % 2 == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/multi_button_debounce.md
Name: multi_button_debounce

Overview:
- Parametrised N-channel successor to the single-button debounce/toggle path for the NANDLAND Go Board (25 MHz, active-high pushbuttons).
- Per channel it provides:
  - input synchronisation;
  - counter-based debounce;
  - one-cycle press and release strobes;
  - a toggle state;
  - optional hold-to-auto-repeat strobes for calculator digit and operator entry.
- Sits between the board button pins and the calculator input decoder.

Parameters:
- NUM_CH, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); must be ≥ 1.
- ACTIVE_HIGH, 1, 1 = pin high means pressed; 0 = pin inverted before synchroniser.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = rpt tied to 0 and repeat FSM states unreachable.
- HOLD_CYCLES, 12500000, cycles from press strobe to first repeat strobe (500 ms); must be ≥ 1.
- REPEAT_CYCLES, 2500000, cycles between subsequent repeat strobes (100 ms); must be ≥ 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- btn_in, input, NUM_CH, raw asynchronous button pins.
- level, output, NUM_CH, debounced pressed state.
- press, output, NUM_CH, one-cycle strobe on accepted press.
- release, output, NUM_CH, one-cycle strobe on accepted release.
- toggle, output, NUM_CH, flips on every press strobe.
- rpt, output, NUM_CH, one-cycle auto-repeat strobe while held.

Behaviour:
- **Decided:** one clock (clk); reset rst_n is synchronous and active-low. All state updates on posedge clk. When rst_n is low at a posedge, the following clear to 0:
  - all synchroniser flops, counters and FSMs (state IDLE);
  - level, press, release, toggle and rpt.
- **Synchroniser:** 2-flop per channel, fed by btn_in XOR !ACTIVE_HIGH. Output s2.
- **Debounce counter**, width $clog2(DEBOUNCE_CYCLES):
  - If s2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- **Latency:** a clean pin change first sampled at edge E appears on level after edge E+1+DEBOUNCE_CYCLES (i.e. D+2 cycles).
- **Glitch rejection:** any s2 disagreement shorter than DEBOUNCE_CYCLES cycles resets cnt and is never reflected on level.
- **press / release:**
  - press[i] is high for exactly the one cycle in which level[i] is first 1; release[i] likewise on the first cycle of 0.
  - Both are registered alongside level (same edge), never both high.
- **toggle[i]:** inverts on the same edge that asserts press[i]. Release has no effect on toggle.
- **Repeat FSM per channel** (states IDLE, HOLD, REPEAT); tmr width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
  - IDLE: on the press edge go to HOLD, tmr <= 0.
  - HOLD: tmr++. When tmr == HOLD_CYCLES-1, assert rpt for one cycle, go to REPEAT, tmr <= 0.
  - REPEAT: tmr++. When tmr == REPEAT_CYCLES-1, assert rpt, tmr <= 0.
  - Any state: on the release edge go to IDLE, tmr <= 0, no rpt that cycle. Release takes priority over a coincident rpt expiry.
  - First rpt occurs HOLD_CYCLES cycles after the press strobe, then every REPEAT_CYCLES cycles, indefinitely while held.
  - With REPEAT_EN = 0, the FSM stays in IDLE and rpt is constant 0.
- **Channel independence:** channels are fully independent; simultaneous events on different channels produce simultaneous strobes.
- **Reset mid-operation:** outputs clear immediately. A button held through reset is seen as a new press D+2 cycles after rst_n rises: press strobe, toggle → 1, repeat restarts from HOLD.
- **Counter wrap:** counters never wrap; each is bounded by its compare-and-clear.

Decomposition:
- Package multi_button_pkg:
  - FSM enum rpt_state_t {IDLE, HOLD, REPEAT};
  - default-timing localparams (CLK_HZ = 25_000_000 and derived cycle counts).
- Sub-module debounce_channel: one channel's synchroniser, debounce counter, strobes, toggle and repeat FSM. The top instantiates it NUM_CH times in a generate loop.

Test Plan (bench overrides DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, NUM_CH=4):
1. **Clean press:** btn_in[0] 0→1 sampled at edge 1. Expect:
   - level[0] = 1 and press[0] = 1 after edge 10, press[0] = 0 after edge 11;
   - toggle[0] = 1;
   - other channels unchanged.
2. **Bounce:** btn_in[1] pulses high 7 cycles, low 3, high 7, then low. Expect level[1], press[1] and toggle[1] all stay 0 throughout.
3. **Auto-repeat:** btn_in[2] held 60 cycles after press. Expect:
   - rpt[2] single-cycle pulses at press+20, +25, +30, ... while held;
   - release[2] pulse 10 cycles after the pin falls;
   - no rpt after release;
   - toggle[2] flips only once.
4. **Toggle:** three clean press/release cycles on ch3. Expect toggle[3] sequence 1, 0, 1; exactly 3 press and 3 release strobes.
5. **Reset mid-hold:** ch0 in REPEAT, drive rst_n low 2 cycles with btn still high. Expect:
   - all outputs 0 during reset;
   - after release of reset, press[0] 10 cycles later with toggle[0] = 1;
   - first rpt 20 cycles after that press.
6. **Parameter modes:** REPEAT_EN=0 build, ch0 held 100 cycles → rpt stays 0. ACTIVE_HIGH=0 build, pin driven low → level = 1 after 10 cycles.
